rot_regfile_loader: RTL
=======================

ROT_REGFILE_LOADER -- requirements
Module: rot_regfile_loader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of target registers (nibble writes per load).
REQ-002 SHALL have parameter ADDR_BITS, default 4, width of w_addr and start_addr.
REQ-003 SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-004 SHALL have ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  async active-low reset.
- start  input  1  begin load, sampled in IDLE only.
- abort  input  1  sync cancel of a load in progress.
- start_addr  input  ADDR_BITS  first register written.
- in_data  input  8  byte: low nibble written first, then high nibble.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts byte this cycle.
- w_addr  output  ADDR_BITS  register-file write address.
- wdata  output  4  register-file write data.
- set_data  output  1  register-file write strobe.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse on load completion.

Function
REQ-005 SHALL implement FSM states IDLE, RECV, WR_LO, WR_HI, DONE.
REQ-006 IDLE: on start=1 and abort=0, SHALL load addr<=start_addr and count<=0, then go to RECV; otherwise stay in IDLE.
REQ-007 RECV: in_ready=1; on in_valid=1, SHALL capture in_data into an 8-bit byte register and go to WR_LO; with in_valid=0, SHALL stay in RECV.
REQ-008 WR_LO: set_data=1, w_addr=addr, wdata=byte[3:0]; SHALL do addr<=addr+1 modulo 2^ADDR_BITS and count<=count+1, then go to WR_HI.
REQ-009 WR_HI: set_data=1, w_addr=addr, wdata=byte[7:4]; SHALL increment addr and count; next state is DONE if this is write number NUM_REGS, else RECV.
REQ-010 DONE: done=1 for exactly one cycle, then SHALL go to IDLE.
REQ-011 in_ready, set_data, w_addr, wdata, busy and done SHALL depend only on registered state (Moore); no combinational path from in_valid, start or abort.
REQ-012 Latency: a byte accepted at edge N SHALL give the low-nibble write in cycle N+1, the high-nibble write in N+2, and in_ready again in N+3 (at most 1 byte per 3 cycles).
REQ-013 Outside WR_LO/WR_HI, set_data SHALL be 0, and w_addr/wdata SHALL hold their last values.
REQ-014 Address SHALL wrap from 2^ADDR_BITS-1 to 0 with no error or flag.
REQ-015 count SHALL be ADDR_BITS+1 bits wide so it can reach NUM_REGS without overflow.
REQ-016 abort=1 in RECV, WR_LO, WR_HI or DONE SHALL force next state IDLE; set_data stays as decoded for the current cycle; done SHALL NOT pulse on an aborted load unless already in DONE.
REQ-017 start in any state other than IDLE SHALL be ignored.
REQ-018 start and abort high together in IDLE: abort SHALL win, and the FSM stays in IDLE.
REQ-019 in_valid in any state other than RECV SHALL be ignored; no byte is captured and in_ready=0.
REQ-020 Each completed load SHALL produce exactly NUM_REGS set_data pulses.

Reset
REQ-021 rst_n=0 SHALL immediately force: state IDLE, addr 0, count 0, byte 0.
REQ-022 rst_n=0 SHALL immediately force outputs in_ready 0, set_data 0, w_addr 0, wdata 0, busy 0, done 0.
REQ-023 Reset mid-load SHALL discard the load; after release, no further set_data occurs until a new start.

Verification
REQ-024 Bench SHALL cover:
- start_addr=0, bytes 0x10,0x32,...,0xFE back-to-back -> 16 writes reg[i]=i; done one cycle after last WR_HI; busy falls with done.
- start_addr=14, bytes 0xBA,0xDC,... -> writes 14=A, 15=B, 0=C, 1=D (wrap); 16 writes total.
- in_valid low for 5 cycles in RECV -> in_ready held 1, no set_data, no byte captured.
- abort asserted in the WR_LO cycle of byte 3 -> that write occurs, next cycle IDLE, busy 0, done never pulses.
- start pulsed while busy, and start+abort in IDLE -> both ignored, no state or address change.
- rst_n low during WR_HI -> set_data/busy drop to 0 the same cycle; after release, idle until start.

Source files
------------

// File: rtl/rot_regfile_loader.sv
// ============================================================================
// rot_regfile_loader: streams bytes into a nibble-wide register file.
// Revision 1.0
// ============================================================================
`default_nettype none

module rot_regfile_loader #(
  parameter int NUM_REGS  = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_BITS-1:0] w_addr,
  output logic [3:0]           wdata,
  output logic                 set_data,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_BITS:0] LAST_COUNT = (ADDR_BITS + 1)'(NUM_REGS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS:0]   count;
  logic [7:0]           data_byte;
  logic [ADDR_BITS-1:0] last_addr;
  logic [3:0]           last_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Write port shows the live address/nibble only while writing, else the last write.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    set_data  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    w_addr    = last_addr;
    wdata     = last_data;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = RECV;
      end
      RECV: begin
        in_ready = 1'b1;
        if (abort)         state_nxt = IDLE;
        else if (in_valid) state_nxt = WR_LO;
      end
      WR_LO: begin
        set_data  = 1'b1;
        w_addr    = addr;
        wdata     = data_byte[3:0];
        state_nxt = abort ? IDLE : WR_HI;
      end
      WR_HI: begin
        set_data = 1'b1;
        w_addr   = addr;
        wdata    = data_byte[7:4];
        if (abort)                    state_nxt = IDLE;
        else if (count == LAST_COUNT) state_nxt = DONE;
        else                          state_nxt = RECV;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      count     <= '0;
      data_byte <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            addr  <= start_addr;
            count <= '0;
          end
        end
        RECV: begin
          if (in_valid && !abort) data_byte <= in_data;
        end
        WR_LO: begin
          addr      <= addr + 1'b1;
          count     <= count + 1'b1;
          last_addr <= addr;
          last_data <= data_byte[3:0];
        end
        WR_HI: begin
          addr      <= addr + 1'b1;
          count     <= count + 1'b1;
          last_addr <= addr;
          last_data <= data_byte[7:4];
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
